// File: rtl/ahb_sram_slave.sv
// AHB-Lite responder in front of a 2^ADDR_W x 32 single-port SRAM with wait states and write-to-read forwarding.
// Define AHB_SRAM_ERR_EN to return a two-cycle ERROR response for oversize or misaligned transfers.
module ahb_sram_slave #(
   parameter int unsigned ADDR_W      = 10,
   parameter int unsigned WAIT_STATES = 0
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              HSEL,
   input  logic [31:0]       HADDR,
   input  logic [1:0]        HTRANS,
   input  logic              HWRITE,
   input  logic [2:0]        HSIZE,
   input  logic [31:0]       HWDATA,
   input  logic              HREADY,
   output logic              HREADYOUT,
   output logic [31:0]       HRDATA,
   output logic              HRESP
);

   localparam int unsigned DEPTH   = 1 << ADDR_W;
   localparam logic [1:0]  WS_LOAD = (WAIT_STATES > 0) ? 2'(WAIT_STATES - 1) : 2'd0;

`ifdef AHB_SRAM_ERR_EN
   typedef enum logic [2:0] {S_IDLE, S_WAIT, S_DATA, S_ERR1, S_ERR2} state_e;
`else
   typedef enum logic [2:0] {S_IDLE, S_WAIT, S_DATA} state_e;
`endif

   logic [31:0]       mem_q [DEPTH];
   state_e            state_q;
   logic [1:0]        cnt_q;
   logic [ADDR_W-1:0] idx_q;
   logic [3:0]        strb_q;
   logic              wr_q;
   logic              hreadyout_q;
   logic              hresp_q;
   logic [31:0]       hrdata_q;
   logic [31:0]       rbuf_q;

   logic              open_d;
   logic              accept_d;
   logic              req_err_d;
   logic              commit_d;
   logic [ADDR_W-1:0] a_idx_d;
   logic [3:0]        a_strb_d;
   logic [31:0]       merged_d;
   logic [31:0]       rd_word_d;
   logic              unused_bits;

   assign unused_bits = ^{HTRANS[0], HADDR[31:ADDR_W+2]};

   function automatic logic [3:0] lane_strb(input logic [2:0] size, input logic [1:0] lane);
      case (size)
         3'd0:    return 4'b0001 << lane;
         3'd1:    return lane[1] ? 4'b1100 : 4'b0011;
         default: return 4'b1111;
      endcase
   endfunction

   always_comb begin
      a_idx_d  = HADDR[ADDR_W+1:2];
      a_strb_d = lane_strb(HSIZE, HADDR[1:0]);
`ifdef AHB_SRAM_ERR_EN
      open_d    = (state_q == S_IDLE) || (state_q == S_DATA) || (state_q == S_ERR2);
      req_err_d = (HSIZE > 3'd2)
               || ((HSIZE == 3'd1) && HADDR[0])
               || ((HSIZE == 3'd2) && (HADDR[1:0] != 2'b00));
`else
      open_d    = (state_q == S_IDLE) || (state_q == S_DATA);
      req_err_d = 1'b0;
`endif
      accept_d = open_d && HSEL && HREADY && HTRANS[1];
      commit_d = (state_q == S_DATA) && wr_q;
      merged_d = mem_q[idx_q];
      for (int unsigned b = 0; b < 4; b++) begin
         if (strb_q[b]) merged_d[8*b +: 8] = HWDATA[8*b +: 8];
      end
      // A read accepted on the committing edge sees the write merged over the old word.
      rd_word_d = (commit_d && (idx_q == a_idx_d)) ? merged_d : mem_q[a_idx_d];
   end

   always_ff @(posedge clk_i) begin
      if (!rst_i && commit_d) mem_q[idx_q] <= merged_d;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         idx_q       <= '0;
         strb_q      <= '0;
         wr_q        <= 1'b0;
         hreadyout_q <= 1'b1;
         hresp_q     <= 1'b0;
         hrdata_q    <= '0;
         rbuf_q      <= '0;
      end else if (accept_d) begin
         idx_q  <= a_idx_d;
         strb_q <= a_strb_d;
         wr_q   <= HWRITE && !req_err_d;
         if (req_err_d) begin
`ifdef AHB_SRAM_ERR_EN
            state_q     <= S_ERR1;
            hreadyout_q <= 1'b0;
            hresp_q     <= 1'b1;
`endif
         end else if (WAIT_STATES > 0) begin
            state_q     <= S_WAIT;
            cnt_q       <= WS_LOAD;
            hreadyout_q <= 1'b0;
            hresp_q     <= 1'b0;
            if (!HWRITE) rbuf_q <= rd_word_d;
         end else begin
            state_q     <= S_DATA;
            hreadyout_q <= 1'b1;
            hresp_q     <= 1'b0;
            if (!HWRITE) hrdata_q <= rd_word_d;
         end
      end else begin
         case (state_q)
            S_WAIT: begin
               if (cnt_q == 2'd0) begin
                  state_q     <= S_DATA;
                  hreadyout_q <= 1'b1;
                  if (!wr_q) hrdata_q <= rbuf_q;
               end else begin
                  cnt_q <= cnt_q - 2'd1;
               end
            end
`ifdef AHB_SRAM_ERR_EN
            S_ERR1: begin
               state_q     <= S_ERR2;
               hreadyout_q <= 1'b1;
               hresp_q     <= 1'b1;
            end
`endif
            default: begin
               state_q     <= S_IDLE;
               hreadyout_q <= 1'b1;
               hresp_q     <= 1'b0;
            end
         endcase
      end
   end

   assign HREADYOUT = hreadyout_q;
   assign HRESP     = hresp_q;
   assign HRDATA    = hrdata_q;

endmodule
